// File: rtl/display_pkg.sv
// Shared raster timing description for the display timing generator.
package display_pkg;

    // Horizontal/vertical phase widths plus sync polarities.
    typedef struct packed {
        int unsigned h_res;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_res;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
        logic        h_pol;
        logic        v_pol;
    } timing_t;

    typedef struct packed {
        int unsigned h;
        int unsigned v;
    } totals_t;

    // 640x480@60, 25.175 MHz pixel clock, both syncs active-low.
    localparam timing_t TIMING_640X480 = '{
        h_res: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_res: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
        h_pol: 1'b0, v_pol: 1'b0
    };

    // Pixels per line and lines per frame.
    function automatic totals_t total(timing_t t);
        totals_t r;
        r.h = t.h_res + t.h_fp + t.h_sync + t.h_bp;
        r.v = t.v_res + t.v_fp + t.v_sync + t.v_bp;
        return r;
    endfunction

endpackage

// File: rtl/display_if.sv
// Raster output bundle: coordinates, syncs, strobes and their delayed copies.
interface display_if #(
    parameter int unsigned CORDW = 11
);
    logic [CORDW-1:0] sx;
    logic [CORDW-1:0] sy;
    logic             hsync;
    logic             vsync;
    logic             de;
    logic             line;
    logic             frame;
    logic             hsync_d;
    logic             vsync_d;
    logic             de_d;
    logic             frame_d;

    modport master (
        output sx, sy, hsync, vsync, de, line, frame,
        output hsync_d, vsync_d, de_d, frame_d
    );

    modport slave (
        input sx, sy, hsync, vsync, de, line, frame,
        input hsync_d, vsync_d, de_d, frame_d
    );
endinterface

// File: rtl/sync_delay.sv
// Fixed-latency shift register with an async reset to a per-bit value.
module sync_delay #(
    parameter int unsigned    W       = 1,
    parameter int unsigned    LAT     = 2,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    if (LAT == 0) begin : g_bypass
        assign o_q = i_d;
    end else begin : g_pipe
        logic [W-1:0] r_pipe [LAT];

        // Shift one stage per clock; reset parks every stage at RST_VAL.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                for (int i = 0; i < int'(LAT); i++) r_pipe[i] <= RST_VAL;
            end else begin
                r_pipe[0] <= i_d;
                for (int i = 1; i < int'(LAT); i++) r_pipe[i] <= r_pipe[i-1];
            end
        end

        assign o_q = r_pipe[LAT-1];
    end

endmodule

// File: rtl/display_timings.sv
// Pixel-clock raster timing generator with LAT-delayed sync/de/frame copies.
module display_timings
    import display_pkg::*;
#(
    parameter int unsigned CORDW  = 11,
    parameter int unsigned H_RES  = TIMING_640X480.h_res,
    parameter int unsigned H_FP   = TIMING_640X480.h_fp,
    parameter int unsigned H_SYNC = TIMING_640X480.h_sync,
    parameter int unsigned H_BP   = TIMING_640X480.h_bp,
    parameter int unsigned V_RES  = TIMING_640X480.v_res,
    parameter int unsigned V_FP   = TIMING_640X480.v_fp,
    parameter int unsigned V_SYNC = TIMING_640X480.v_sync,
    parameter int unsigned V_BP   = TIMING_640X480.v_bp,
    parameter bit          H_POL  = TIMING_640X480.h_pol,
    parameter bit          V_POL  = TIMING_640X480.v_pol,
    parameter int unsigned LAT    = 2
) (
    input  logic      clk_pix,
    input  logic      rst_pix_n,
    display_if.master bus
);

    localparam timing_t TIM = '{
        h_res: H_RES, h_fp: H_FP, h_sync: H_SYNC, h_bp: H_BP,
        v_res: V_RES, v_fp: V_FP, v_sync: V_SYNC, v_bp: V_BP,
        h_pol: H_POL, v_pol: V_POL
    };
    localparam totals_t     TOT     = total(TIM);
    localparam int unsigned H_TOTAL = TOT.h;
    localparam int unsigned V_TOTAL = TOT.v;

    if (CORDW == 0 || H_RES == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_RES == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_err_zero
        $error("display_timings: every width parameter must be non-zero");
    end
    if (LAT > 15) begin : g_err_lat
        $error("display_timings: LAT must be 0..15");
    end
    if ($clog2(H_TOTAL) > CORDW || $clog2(V_TOTAL) > CORDW) begin : g_err_cordw
        $error("display_timings: CORDW too narrow for H_TOTAL-1 or V_TOTAL-1");
    end

    localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] H_ACT  = CORDW'(H_RES);
    localparam logic [CORDW-1:0] V_ACT  = CORDW'(V_RES);
    localparam logic [CORDW-1:0] HS_BEG = CORDW'(H_RES + H_FP);
    localparam logic [CORDW-1:0] HS_END = CORDW'(H_RES + H_FP + H_SYNC);
    localparam logic [CORDW-1:0] VS_BEG = CORDW'(V_RES + V_FP);
    localparam logic [CORDW-1:0] VS_END = CORDW'(V_RES + V_FP + V_SYNC);

    logic [CORDW-1:0] r_sx, r_sy;
    logic [CORDW-1:0] w_sx_nxt, w_sy_nxt;
    logic             r_hsync, r_vsync, r_de, r_line, r_frame;
    logic             w_hsync, w_vsync, w_de, w_line, w_frame;
    logic [3:0]       w_dly;

    // Next raster position: sx wraps every line, sy steps only on that wrap.
    always_comb begin
        w_sx_nxt = r_sx + 1'b1;
        w_sy_nxt = r_sy;
        if (r_sx == H_LAST) begin
            w_sx_nxt = '0;
            w_sy_nxt = (r_sy == V_LAST) ? '0 : r_sy + 1'b1;
        end
    end

    // Decode from the next position so registered outputs line up with sx/sy.
    always_comb begin
        w_hsync = (w_sx_nxt >= HS_BEG && w_sx_nxt < HS_END) ? H_POL : ~H_POL;
        w_vsync = (w_sy_nxt >= VS_BEG && w_sy_nxt < VS_END) ? V_POL : ~V_POL;
        w_de    = (w_sx_nxt < H_ACT) && (w_sy_nxt < V_ACT);
        w_line  = (w_sx_nxt == '0);
        w_frame = (w_sx_nxt == '0) && (w_sy_nxt == '0);
    end

    // Reset parks the raster on the last pixel so the first edge starts a frame.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_sx    <= H_LAST;
            r_sy    <= V_LAST;
            r_hsync <= ~H_POL;
            r_vsync <= ~V_POL;
            r_de    <= 1'b0;
            r_line  <= 1'b0;
            r_frame <= 1'b0;
        end else begin
            r_sx    <= w_sx_nxt;
            r_sy    <= w_sy_nxt;
            r_hsync <= w_hsync;
            r_vsync <= w_vsync;
            r_de    <= w_de;
            r_line  <= w_line;
            r_frame <= w_frame;
        end
    end

    sync_delay #(
        .W       (4),
        .LAT     (LAT),
        .RST_VAL ({~H_POL, ~V_POL, 1'b0, 1'b0})
    ) u_sync_delay (
        .i_clk   (clk_pix),
        .i_rst_n (rst_pix_n),
        .i_d     ({r_hsync, r_vsync, r_de, r_frame}),
        .o_q     (w_dly)
    );

    assign bus.sx      = r_sx;
    assign bus.sy      = r_sy;
    assign bus.hsync   = r_hsync;
    assign bus.vsync   = r_vsync;
    assign bus.de      = r_de;
    assign bus.line    = r_line;
    assign bus.frame   = r_frame;
    assign bus.hsync_d = w_dly[3];
    assign bus.vsync_d = w_dly[2];
    assign bus.de_d    = w_dly[1];
    assign bus.frame_d = w_dly[0];

endmodule

// File: tb/tb_display_timings.sv
// Scoreboard bench: three raster generators (two small custom timings, one default
// 640x480) run from one clock and reset and are compared against a cycle-count model.
module tb_display_timings;

    typedef struct {
        int hres, hfp, hsync, hbp;
        int vres, vfp, vsync, vbp;
        bit hpol, vpol;
        int lat;
    } tp_t;

    typedef struct {
        int n;
        int sx, sy;
        bit hs, vs, de, line, frame;
        bit hs_d, vs_d, de_d, fr_d;
    } exp_t;

    localparam tp_t PA = '{hres: 16, hfp: 2, hsync: 3, hbp: 4,
                           vres: 8, vfp: 1, vsync: 2, vbp: 3,
                           hpol: 1'b0, vpol: 1'b0, lat: 2};
    localparam tp_t PB = '{hres: 12, hfp: 1, hsync: 2, hbp: 2,
                           vres: 6, vfp: 2, vsync: 1, vbp: 2,
                           hpol: 1'b1, vpol: 1'b1, lat: 0};
    localparam tp_t PC = '{hres: 640, hfp: 16, hsync: 96, hbp: 48,
                           vres: 480, vfp: 10, vsync: 2, vbp: 33,
                           hpol: 1'b0, vpol: 1'b0, lat: 2};

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    display_if #(.CORDW(5))  bus_a ();
    display_if #(.CORDW(6))  bus_b ();
    display_if #(.CORDW(11)) bus_c ();

    display_timings #(
        .CORDW(5), .H_RES(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_RES(8), .V_FP(1), .V_SYNC(2), .V_BP(3),
        .H_POL(1'b0), .V_POL(1'b0), .LAT(2)
    ) dut_a (.clk_pix(clk), .rst_pix_n(rst_n), .bus(bus_a));

    display_timings #(
        .CORDW(6), .H_RES(12), .H_FP(1), .H_SYNC(2), .H_BP(2),
        .V_RES(6), .V_FP(2), .V_SYNC(1), .V_BP(2),
        .H_POL(1'b1), .V_POL(1'b1), .LAT(0)
    ) dut_c_small (.clk_pix(clk), .rst_pix_n(rst_n), .bus(bus_b));

    display_timings dut_def (.clk_pix(clk), .rst_pix_n(rst_n), .bus(bus_c));

    int total = 0;
    int bad   = 0;
    exp_t q_a[$], q_b[$], q_c[$];

    // Undelayed outputs n edges after reset release (n<0: held in reset).
    function automatic exp_t raw(tp_t p, int n);
        exp_t e;
        int ht = p.hres + p.hfp + p.hsync + p.hbp;
        int vt = p.vres + p.vfp + p.vsync + p.vbp;
        e.n = n;
        if (n < 0) begin
            e.sx = ht - 1;  e.sy = vt - 1;
            e.hs = !p.hpol; e.vs = !p.vpol;
            e.de = 0; e.line = 0; e.frame = 0;
        end else begin
            e.sx    = n % ht;
            e.sy    = (n / ht) % vt;
            e.hs    = (e.sx >= p.hres + p.hfp && e.sx < p.hres + p.hfp + p.hsync)
                      ? p.hpol : !p.hpol;
            e.vs    = (e.sy >= p.vres + p.vfp && e.sy < p.vres + p.vfp + p.vsync)
                      ? p.vpol : !p.vpol;
            e.de    = (e.sx < p.hres) && (e.sy < p.vres);
            e.line  = (e.sx == 0);
            e.frame = (e.sx == 0) && (e.sy == 0);
        end
        return e;
    endfunction

    // Full expectation: delayed copies are the undelayed values LAT edges earlier.
    function automatic exp_t model(tp_t p, int n);
        exp_t e = raw(p, n);
        exp_t d = raw(p, (n < 0) ? -1 : n - p.lat);
        e.hs_d = d.hs; e.vs_d = d.vs; e.de_d = d.de; e.fr_d = d.frame;
        return e;
    endfunction

    function automatic exp_t pack(int sx, int sy, bit hs, bit vs, bit de, bit ln, bit fr,
                                  bit hs_d, bit vs_d, bit de_d, bit fr_d);
        exp_t a;
        a.n = 0; a.sx = sx; a.sy = sy; a.hs = hs; a.vs = vs; a.de = de;
        a.line = ln; a.frame = fr; a.hs_d = hs_d; a.vs_d = vs_d; a.de_d = de_d;
        a.fr_d = fr_d;
        return a;
    endfunction

    task automatic check(string name, int n, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at n=%0d: got %0d expected %0d", name, n, act, exp);
        end
    endtask

    task automatic compare_all(string tag, exp_t e, exp_t a);
        check({tag, ".sx"},      e.n, a.sx,    e.sx);
        check({tag, ".sy"},      e.n, a.sy,    e.sy);
        check({tag, ".hsync"},   e.n, a.hs,    e.hs);
        check({tag, ".vsync"},   e.n, a.vs,    e.vs);
        check({tag, ".de"},      e.n, a.de,    e.de);
        check({tag, ".line"},    e.n, a.line,  e.line);
        check({tag, ".frame"},   e.n, a.frame, e.frame);
        check({tag, ".hsync_d"}, e.n, a.hs_d,  e.hs_d);
        check({tag, ".vsync_d"}, e.n, a.vs_d,  e.vs_d);
        check({tag, ".de_d"},    e.n, a.de_d,  e.de_d);
        check({tag, ".frame_d"}, e.n, a.fr_d,  e.fr_d);
    endtask

    task automatic push_all(int n);
        q_a.push_back(model(PA, n));
        q_b.push_back(model(PB, n));
        q_c.push_back(model(PC, n));
    endtask

    // Monitor: one expectation per DUT per cycle, sampled on the falling edge.
    always @(negedge clk) begin
        if (q_a.size() > 0)
            compare_all("A", q_a.pop_front(),
                pack(int'(bus_a.sx), int'(bus_a.sy), bus_a.hsync, bus_a.vsync, bus_a.de,
                     bus_a.line, bus_a.frame, bus_a.hsync_d, bus_a.vsync_d, bus_a.de_d,
                     bus_a.frame_d));
        if (q_b.size() > 0)
            compare_all("B", q_b.pop_front(),
                pack(int'(bus_b.sx), int'(bus_b.sy), bus_b.hsync, bus_b.vsync, bus_b.de,
                     bus_b.line, bus_b.frame, bus_b.hsync_d, bus_b.vsync_d, bus_b.de_d,
                     bus_b.frame_d));
        if (q_c.size() > 0)
            compare_all("C", q_c.pop_front(),
                pack(int'(bus_c.sx), int'(bus_c.sy), bus_c.hsync, bus_c.vsync, bus_c.de,
                     bus_c.line, bus_c.frame, bus_c.hsync_d, bus_c.vsync_d, bus_c.de_d,
                     bus_c.frame_d));
    end

    // Driver: reset, run past two default lines, reset mid-line, resume.
    initial begin
        int mid_n;
        int hold;
        int tail;
        // A at sx=10, sy=5 of its second frame.
        mid_n = 350 + 5 * 25 + 10;
        hold  = 2 + int'($urandom_range(0, 3));
        tail  = 700 + int'($urandom_range(0, 50));
        #1 rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            push_all(-1);
        end
        rst_n = 1'b1;
        for (int i = 0; i < mid_n + 1500; i++) begin
            @(posedge clk); #1;
            push_all(i);
        end
        // Asynchronous assertion between edges; the same cycle must show reset values.
        @(posedge clk); #1;
        rst_n = 1'b0;
        push_all(-1);
        repeat (hold) begin
            @(posedge clk); #1;
            push_all(-1);
        end
        rst_n = 1'b1;
        for (int i = 0; i < tail; i++) begin
            @(posedge clk); #1;
            push_all(i);
        end
        @(negedge clk); #1;
        check("A.drain", 0, q_a.size(), 0);
        check("B.drain", 0, q_b.size(), 0);
        check("C.drain", 0, q_c.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
